serpent_stream_adapter: RTL
===========================

Name: serpent_stream_adapter

Overview:
- Valid/ready stream front-end and back-end for the free-running 33-stage pipelined Serpent encrypt core.
- The core has no valid, enable or stall. This block tracks which pipeline slots carry real blocks and buffers finished ciphertext in an output FIFO.
- It admits a new block only when a FIFO slot is already reserved for it, so no result is ever lost under downstream backpressure.
- Sits between the system stream source/sink and the core; the core connects through the core_din/core_dout ports.

Parameters:
- LATENCY, 33, cycles from core sampling core_din at edge k to result stable on core_dout after edge k+32 (valid-tracking depth).
- FIFO_DEPTH, 64, output FIFO entries; power of two, must be at least 2. Full throughput requires FIFO_DEPTH >= LATENCY+1.
- TAG_W, 8, tag width (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock shared with the core.
- rst  input  1  reset, asynchronous, active-high.
- s_valid  input  1  upstream block valid.
- s_ready  output  1  adapter can accept a block this cycle.
- s_data  input  128  plaintext block.
- core_din  output  128  to core data_in.
- core_dout  input  128  from core data_out.
- m_valid  output  1  ciphertext available at FIFO head.
- m_ready  input  1  downstream accepts.
- m_data  output  128  ciphertext at FIFO head.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- err_ovf  output  1  sticky overflow flag.

Behaviour:
- Reset values (asynchronous; rst is the only reset): valid shift register all 0; FIFO empty; credit_cnt = FIFO_DEPTH; m_valid = 0; fifo_level = 0; err_ovf = 0; s_ready = 0 while rst is high.
- Accept: accept = s_valid && s_ready. s_ready = (credit_cnt != 0) && !rst, driven from registers only (no combinational path from s_valid or m_ready).
- core_din = s_data, combinationally. The core samples it every edge; non-accepted cycles are marked invalid.
- Valid tracking: vld_sr[0] <= accept; vld_sr[i] <= vld_sr[i-1].
- FIFO push: when vld_sr[LATENCY-1] = 1, push core_dout. The push happens at the edge after vld_sr[LATENCY-1] sets.
- Latency: block accepted at edge k is pushed at edge k+33; m_valid rises after edge k+33 (34 cycles accept-to-output, FIFO empty).
- Pop: pop = m_valid && m_ready. m_data is the FIFO head, held stable while m_valid && !m_ready. m_valid is never deasserted without a pop.
- Credits: each accept decrements credit_cnt; each pop increments it; accept and pop in the same cycle leave it unchanged. Therefore in-flight count + fifo_level + credit_cnt = FIFO_DEPTH at all times.
- Simultaneous push and pop: allowed at any occupancy, including empty (the pushed entry appears the next cycle) and full.
- Pointers: read/write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. fifo_level is updated +1 on push-only, -1 on pop-only, unchanged on both.
- Overflow: a push while fifo_level == FIFO_DEPTH with no pop is unreachable by construction. If it occurs, the entry is dropped and err_ovf sets and stays set until rst.
- Reset mid-operation: in-flight and buffered blocks are discarded. The core's unreset registers hold stale data, but vld_sr = 0 guarantees none of it reaches the FIFO.
- Ordering: strict FIFO order; no reordering or duplication.

Optional Feature:
- Macro: SERPENT_ADAPTER_TAG_EN.
- When defined: adds ports s_tag (input, TAG_W) and m_tag (output, TAG_W).
  - The tag is captured on accept and carried in a LATENCY-deep tag shift register in parallel with vld_sr.
  - It is stored in the FIFO beside the data, and m_tag follows the same stability rules as m_data.
  - m_tag resets to 0.
- When undefined: no tag ports, no tag storage; behaviour is otherwise identical.

Test Plan:
- Test core stub: a 33-stage delay that outputs ~din, standing in for the real core.
1. Reset release, then a single block s_data = 128'h1 with m_ready = 1 -> m_valid pulses exactly 34 cycles after accept, m_data = ~128'h1; credit returns to 64.
2. Stream 200 back-to-back blocks (values 0..199) with m_ready = 1 -> s_ready stays 1, one output per cycle after fill, values ~0..~199 in order.
3. m_ready = 0 while streaming -> exactly 64 blocks accepted, then s_ready = 0; fifo_level reaches 64; err_ovf stays 0. Then m_ready = 1 -> all 64 drain in order and s_ready reasserts the cycle after the first pop.
4. Alternate m_ready 1/0 each cycle with continuous s_valid -> no loss or duplication; m_data stable while stalled; err_ovf = 0.
5. Assert rst with 20 blocks in flight and 5 buffered -> m_valid = 0 immediately; after release, no stale outputs within 40 cycles; a fresh block 128'hA5 produces ~128'hA5 after 34 cycles.
6. Tag feature, with SERPENT_ADAPTER_TAG_EN defined: tags 0x10..0x1F on 16 blocks -> m_tag matches each tag alongside its m_data.

Source files
------------

// File: rtl/serpent_stream_adapter.sv
// Valid/ready wrapper around a free-running LATENCY-stage pipelined Serpent core.
// Optional tag side-band is compiled in with the SERPENT_ADAPTER_TAG_EN macro.
module serpent_stream_adapter #(
    parameter int LATENCY    = 33,
    parameter int FIFO_DEPTH = 64,
    parameter int TAG_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [127:0]                s_data,
`ifdef SERPENT_ADAPTER_TAG_EN
    input  logic [TAG_W-1:0]            s_tag,
    output logic [TAG_W-1:0]            m_tag,
`endif
    output logic [127:0]                core_din,
    input  logic [127:0]                core_dout,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [127:0]                m_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        err_ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [LVL_W-1:0]   credit_q, credit_d;
    logic               m_valid_q, m_valid_d;
    logic               s_ready_q, s_ready_d;
    logic               err_ovf_q, err_ovf_d;
    logic [127:0]       fifo_mem_q [FIFO_DEPTH];

    logic accept_s;
    logic pop_s;
    logic push_s;
    logic full_s;
    logic wr_en_s;

    // Next-state logic: valid tracking, credit accounting and FIFO pointers.
    always_comb begin
        accept_s  = s_valid && s_ready;
        pop_s     = m_valid_q && m_ready;
        push_s    = vld_sr_q[LATENCY-1];
        full_s    = (level_q == LVL_W'(FIFO_DEPTH));
        wr_en_s   = push_s && (!full_s || pop_s);

        vld_sr_d  = {vld_sr_q[LATENCY-2:0], accept_s};
        wr_ptr_d  = wr_ptr_q + PTR_W'(wr_en_s);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop_s);
        level_d   = level_q;
        credit_d  = credit_q;
        err_ovf_d = err_ovf_q;

        case ({wr_en_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        case ({accept_s, pop_s})
            2'b10:   credit_d = credit_q - LVL_W'(1);
            2'b01:   credit_d = credit_q + LVL_W'(1);
            default: credit_d = credit_q;
        endcase

        // Credits make this unreachable; if it ever fires the entry is dropped.
        if (push_s && full_s && !pop_s) begin
            err_ovf_d = 1'b1;
        end else begin
            err_ovf_d = err_ovf_q;
        end

        m_valid_d = (level_d != {LVL_W{1'b0}});
        s_ready_d = (credit_d != {LVL_W{1'b0}});
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr_q  <= {LATENCY{1'b0}};
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            level_q   <= {LVL_W{1'b0}};
            credit_q  <= LVL_W'(FIFO_DEPTH);
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            err_ovf_q <= 1'b0;
        end else begin
            vld_sr_q  <= vld_sr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            credit_q  <= credit_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    // FIFO data storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            fifo_mem_q[wr_ptr_q] <= core_dout;
        end
    end

`ifdef SERPENT_ADAPTER_TAG_EN
    logic [TAG_W-1:0] tag_sr_q [LATENCY];
    logic [TAG_W-1:0] tag_sr_d [LATENCY];
    logic [TAG_W-1:0] tag_mem_q [FIFO_DEPTH];

    // Tag shift register runs in lockstep with the valid shift register.
    always_comb begin
        if (accept_s) begin
            tag_sr_d[0] = s_tag;
        end else begin
            tag_sr_d[0] = {TAG_W{1'b0}};
        end
        for (int i = 1; i < LATENCY; i++) begin
            tag_sr_d[i] = tag_sr_q[i-1];
        end
    end

    // Tag pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_sr_q[i] <= {TAG_W{1'b0}};
            end
        end else begin
            tag_sr_q <= tag_sr_d;
        end
    end

    // Tag storage beside the FIFO data.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            tag_mem_q[wr_ptr_q] <= tag_sr_q[LATENCY-1];
        end
    end

    assign m_tag = m_valid_q ? tag_mem_q[rd_ptr_q] : {TAG_W{1'b0}};
`else
    logic [TAG_W-1:0] tag_unused_s;
    assign tag_unused_s = {TAG_W{1'b0}};
`endif

    assign s_ready    = s_ready_q && !rst;
    assign core_din   = s_data;
    assign m_valid    = m_valid_q;
    assign m_data     = fifo_mem_q[rd_ptr_q];
    assign fifo_level = level_q;
    assign err_ovf    = err_ovf_q;

endmodule
